// File: rtl/posit_extract.sv
// posit_extract: two-stage posit field extraction ahead of the posit adder core.
// Latency 2 cycles from input transfer to out_valid; throughput 1 word/cycle.
// Backpressure: in_ready = !s1_valid || s1 advances (combinational from out_ready, no skid).
//
// Ports: clk, reset (sync, active-high); In/in_valid/in_ready input handshake;
//   out_valid/out_ready output handshake; Sign, InRemain, RegimeValue, Exponent,
//   Mantissa, zero, nar output fields (registered, held while stalled).
// Optional: define POSIT_EXTRACT_STATS_EN to add saturating word_count and
//   special_count output counters (count output transfers / zero-or-NaR transfers).
module posit_extract #(
  parameter int N  = 8,
  parameter int ES = 3,
  localparam int RS = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N-1:0]         In,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 Sign,
  output logic signed [N-2:0]  InRemain,
  output logic signed [RS:0]   RegimeValue,
  output logic [ES-1:0]        Exponent,
  output logic [N-ES+2:0]      Mantissa,
  output logic                 zero,
`ifdef POSIT_EXTRACT_STATS_EN
  output logic                 nar,
  output logic [15:0]          word_count,
  output logic [15:0]          special_count
`else
  output logic                 nar
`endif
);

  // Stage 1 registers
  logic         s1_valid;
  logic         s1_sign;
  logic [N-2:0] s1_rem;
  logic         s1_zero;
  logic         s1_nar;

  logic s2_load;
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_load;

  // Stage 1 combinational: two's-complement the body for negative posits.
  logic [N-2:0] body_c;
  assign body_c = In[N-1] ? ((N-1)'(0) - In[N-2:0]) : In[N-2:0];

  // Stage 2 combinational: regime run length, regime value, field alignment.
  logic          run_bit;
  logic [RS:0]   run_len;
  logic          run_done;
  logic [RS:0]   shamt;
  logic [N-2:0]  shifted;
  logic [RS:0]   rv_c;

  always_comb begin
    run_bit  = s1_rem[N-2];
    run_len  = '0;
    run_done = 1'b0;
    for (int i = N-2; i >= 0; i--) begin
      if (!run_done && (s1_rem[i] == run_bit)) begin
        run_len = run_len + (RS+1)'(1);
      end else begin
        run_done = 1'b1;
      end
    end
    // Skip the regime run plus its terminating bit, clamped to the body width.
    if (run_len >= (RS+1)'(N-1)) begin
      shamt = (RS+1)'(N-1);
    end else begin
      shamt = run_len + (RS+1)'(1);
    end
    shifted = s1_rem << shamt;
    rv_c    = run_bit ? (run_len - (RS+1)'(1)) : ((RS+1)'(0) - run_len);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid    <= 1'b0;
      s1_sign     <= 1'b0;
      s1_rem      <= '0;
      s1_zero     <= 1'b0;
      s1_nar      <= 1'b0;
      out_valid   <= 1'b0;
      Sign        <= 1'b0;
      InRemain    <= '0;
      RegimeValue <= '0;
      Exponent    <= '0;
      Mantissa    <= '0;
      zero        <= 1'b0;
      nar         <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= in_valid;
        if (in_valid) begin
          s1_sign <= In[N-1];
          s1_rem  <= body_c;
          s1_zero <= (In == '0);
          s1_nar  <= (In == {1'b1, {(N-1){1'b0}}});
        end
      end
      if (s2_load) begin
        out_valid <= s1_valid;
        // Data only changes when a real word moves in, so bubbles keep old fields.
        if (s1_valid) begin
          Sign     <= s1_sign;
          InRemain <= s1_rem;
          zero     <= s1_zero;
          nar      <= s1_nar;
          if (s1_zero || s1_nar) begin
            RegimeValue <= '0;
            Exponent    <= '0;
            Mantissa    <= '0;
          end else begin
            RegimeValue <= rv_c;
            Exponent    <= shifted[N-2 -: ES];
            Mantissa    <= {1'b1, shifted[N-2-ES:0], 3'b000};
          end
        end
      end
    end
  end

`ifdef POSIT_EXTRACT_STATS_EN
  logic out_xfer;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      word_count    <= '0;
      special_count <= '0;
    end else if (out_xfer) begin
      if (word_count != 16'hFFFF) begin
        word_count <= word_count + 16'd1;
      end
      if ((zero || nar) && (special_count != 16'hFFFF)) begin
        special_count <= special_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_posit_extract.sv
// tb_posit_extract: directed, table-driven bench for posit_extract (N=8, ES=3).
// Single vectors are pushed through an otherwise idle pipeline and checked at
// the expected latency; hand sequences cover reset, mid-flight reset and stalls.
module tb_posit_extract;

  logic              clk;
  logic              reset;
  logic [7:0]        In;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic              Sign;
  logic signed [6:0] InRemain;
  logic signed [3:0] RegimeValue;
  logic [2:0]        Exponent;
  logic [7:0]        Mantissa;
  logic              zero;
  logic              nar;
`ifdef POSIT_EXTRACT_STATS_EN
  logic [15:0]       word_count;
  logic [15:0]       special_count;
`endif

  posit_extract #(.N(8), .ES(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .In          (In),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .Sign        (Sign),
    .InRemain    (InRemain),
    .RegimeValue (RegimeValue),
    .Exponent    (Exponent),
    .Mantissa    (Mantissa),
    .zero        (zero),
`ifdef POSIT_EXTRACT_STATS_EN
    .nar         (nar),
    .word_count  (word_count),
    .special_count(special_count)
`else
    .nar         (nar)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] in;
    logic       sign;
    logic [6:0] rem;
    logic [3:0] rv;
    logic [2:0] ex;
    logic [7:0] mant;
    logic       z;
    logic       n;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [24:0] pack_vec(input vec_t v);
    return {v.sign, v.rem, v.rv, v.ex, v.mant, v.z, v.n};
  endfunction

  function automatic logic [24:0] out_bus();
    return {Sign, InRemain, RegimeValue, Exponent, Mantissa, zero, nar};
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    @(negedge clk);
    In       = v.in;
    in_valid = 1'b1;
    #1;
    check($sformatf("in_ready_idle[%0d]", idx), {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check($sformatf("early_valid[%0d]", idx), {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    #1;
    check($sformatf("out_valid[%0d]", idx), {31'd0, out_valid}, 32'd1);
    check($sformatf("sign[%0d]", idx),  {31'd0, Sign},        {31'd0, v.sign});
    check($sformatf("rem[%0d]", idx),   {25'd0, InRemain},    {25'd0, v.rem});
    check($sformatf("rv[%0d]", idx),    {28'd0, RegimeValue}, {28'd0, v.rv});
    check($sformatf("exp[%0d]", idx),   {29'd0, Exponent},    {29'd0, v.ex});
    check($sformatf("mant[%0d]", idx),  {24'd0, Mantissa},    {24'd0, v.mant});
    check($sformatf("zero[%0d]", idx),  {31'd0, zero},        {31'd0, v.z});
    check($sformatf("nar[%0d]", idx),   {31'd0, nar},         {31'd0, v.n});
  endtask

  initial begin
    //          in     sign rem    rv     ex    mant   z  n
    vecs[0]  = '{8'h72, 0, 7'h72, 4'd2,  3'd2, 8'h80, 0, 0};
    vecs[1]  = '{8'h4F, 0, 7'h4F, 4'd0,  3'd3, 8'hE0, 0, 0};
    vecs[2]  = '{8'h8E, 1, 7'h72, 4'd2,  3'd2, 8'h80, 0, 0};
    vecs[3]  = '{8'h00, 0, 7'h00, 4'd0,  3'd0, 8'h00, 1, 0};
    vecs[4]  = '{8'h80, 1, 7'h00, 4'd0,  3'd0, 8'h00, 0, 1};
    vecs[5]  = '{8'h7F, 0, 7'h7F, 4'd6,  3'd0, 8'h80, 0, 0};
    vecs[6]  = '{8'h6E, 0, 7'h6E, 4'd1,  3'd7, 8'h80, 0, 0};
    vecs[7]  = '{8'h01, 0, 7'h01, 4'hA,  3'd0, 8'h80, 0, 0};
    vecs[8]  = '{8'h12, 0, 7'h12, 4'hE,  3'd1, 8'h80, 0, 0};
    vecs[9]  = '{8'h3B, 0, 7'h3B, 4'hF,  3'd6, 8'hE0, 0, 0};
    vecs[10] = '{8'hFF, 1, 7'h01, 4'hA,  3'd0, 8'h80, 0, 0};
    vecs[11] = '{8'hC0, 1, 7'h40, 4'd0,  3'd0, 8'h80, 0, 0};
    vecs[12] = '{8'h5A, 0, 7'h5A, 4'd0,  3'd6, 8'hC0, 0, 0};
    vecs[13] = '{8'h9D, 1, 7'h63, 4'd1,  3'd1, 8'hC0, 0, 0};

    // Reset held 3 cycles with a valid input presented.
    reset     = 1'b1;
    in_valid  = 1'b1;
    In        = 8'h72;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("reset_outputs[%0d]", c), {6'd0, out_valid, out_bus()}, 32'd0);
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

    // Table-driven single-word checks.
    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], i);
    end

    // Reset while a word sits in stage 1: it must never appear.
    @(negedge clk);
    In       = 8'h4F;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check($sformatf("midreset_no_output[%0d]", c), {31'd0, out_valid}, 32'd0);
    end

    // Back-to-back 72, 6E, 4F with out_ready low on cycles 3..5.
    begin
      vec_t       bp_in [3];
      logic [24:0] held;
      logic        stalled;
      int          idx;
      int          oidx;
      bp_in[0] = vecs[0];
      bp_in[1] = vecs[6];
      bp_in[2] = vecs[1];
      idx     = 0;
      oidx    = 0;
      stalled = 1'b0;
      held    = '0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        out_ready = !(c >= 3 && c <= 5);
        in_valid  = (idx < 3);
        In        = (idx < 3) ? bp_in[idx].in : 8'h00;
        #1;
        if (c == 3) begin
          check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        end
        if (stalled) begin
          check($sformatf("bp_hold[%0d]", c), {7'd0, out_bus()}, {7'd0, held});
        end
        stalled = out_valid && !out_ready;
        if (stalled) held = out_bus();
        if (out_valid && out_ready) begin
          if (oidx < 3) begin
            check($sformatf("bp_out[%0d]", oidx), {7'd0, out_bus()}, {7'd0, pack_vec(bp_in[oidx])});
          end else begin
            check("bp_extra_output", {31'd0, out_valid}, 32'd0);
          end
          oidx++;
        end
        if (in_valid && in_ready) idx++;
      end
      in_valid = 1'b0;
      check("bp_words_out", oidx, 32'd3);
`ifdef POSIT_EXTRACT_STATS_EN
      check("word_count", {16'd0, word_count}, 32'd3);
      check("special_count", {16'd0, special_count}, 32'd0);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
